// File: rtl/mcu_timer.sv
// Programmable down-counting timer with prescaler and auto-reload/one-shot modes.
// Loaded and started by the MCU controller; raises a one-cycle interrupt on expiry.
module mcu_timer #(
   parameter int WIDTH       = 16,
   parameter int PRESCALE    = 1,
   parameter bit AUTO_RELOAD = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             timer_cs,
   input  logic             timer_wr,
   input  logic             timer_start,
   input  logic             timer_rd,
   input  logic [WIDTH-1:0] timer_datain,
   output logic [WIDTH-1:0] timer_value,
   output logic             timer_int,
   output logic             running,
   output logic [1:0]       dbg_state
);

   localparam int PW = $clog2(PRESCALE) + 1;
   localparam logic [PW-1:0] PCNT_LAST = PW'(PRESCALE - 1);

   typedef enum logic [1:0] {
      ST_STOP = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [PW-1:0]    pcnt_q, pcnt_d;
   logic [WIDTH-1:0] value_q, value_d;
   logic             int_q, int_d;
   logic             running_q, running_d;

   always_comb begin
      state_d  = state_q;
      reload_d = reload_q;
      count_d  = count_q;
      pcnt_d   = pcnt_q;
      value_d  = value_q;
      int_d    = 1'b0;
      if (timer_cs) begin
         // The read snapshot always takes the count as it was before this edge.
         if (timer_rd) begin
            value_d = count_q;
         end
         if (timer_wr) begin
            reload_d = timer_datain;
            count_d  = timer_datain;
            pcnt_d   = '0;
            state_d  = ST_STOP;
         end else begin
            case (state_q)
               ST_STOP: begin
                  if (timer_start) begin
                     state_d = ST_RUN;
                     pcnt_d  = '0;
                  end
               end
               ST_RUN: begin
                  if (!timer_start) begin
                     state_d = ST_STOP;
                     pcnt_d  = '0;
                  end else if (pcnt_q == PCNT_LAST) begin
                     pcnt_d = '0;
                     if (count_q != '0) begin
                        count_d = count_q - WIDTH'(1);
                     end else begin
                        int_d = 1'b1;
                        if (AUTO_RELOAD) begin
                           count_d = reload_q;
                        end else begin
                           state_d = ST_DONE;
                        end
                     end
                  end else begin
                     pcnt_d = pcnt_q + PW'(1);
                  end
               end
               ST_DONE: begin
                  if (!timer_start) begin
                     state_d = ST_STOP;
                  end
               end
               default: state_d = ST_STOP;
            endcase
         end
      end
      running_d = (state_d == ST_RUN);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_STOP;
         reload_q  <= '0;
         count_q   <= '0;
         pcnt_q    <= '0;
         value_q   <= '0;
         int_q     <= 1'b0;
         running_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         reload_q  <= reload_d;
         count_q   <= count_d;
         pcnt_q    <= pcnt_d;
         value_q   <= value_d;
         int_q     <= int_d;
         running_q <= running_d;
      end
   end

   assign timer_value = value_q;
   assign timer_int   = int_q;
   assign running     = running_q;
   assign dbg_state   = state_q;

endmodule
